// File: rtl/fifo_uart_tx.sv
// UART-style serial transmitter that drains a show-ahead FIFO read port.
// One start bit, WIDTH data bits LSB first, one stop bit; frames stream back-to-back.
module fifo_uart_tx #(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic             rclk,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] dat_i,
    input  logic             empty,
    output logic             rd_o,
    output logic             tx_o,
    output logic             busy_o
);

    localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e           state_q, state_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             bit_end;
    logic             pop;

    always_comb begin
        bit_end = (tmr_q == TW'(CLKS_PER_BIT - 1));
        // Gated by reset so a non-empty FIFO is never popped while held in reset.
        pop     = !rst_i && !empty &&
                  ((state_q == StIdle) || ((state_q == StStop) && bit_end));

        state_d = state_q;
        tmr_d   = tmr_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;

        if (state_q != StIdle) begin
            tmr_d = bit_end ? '0 : tmr_q + TW'(1);
        end

        case (state_q)
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    if (idx_q == IW'(WIDTH - 1)) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + IW'(1);
                        tx_d    = shift_d[0];
                    end
                end
            end
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            end
            default: ;
        endcase

        // A pop from IDLE or the last stop cycle starts a new frame with no gap.
        if (pop) begin
            shift_d = dat_i;
            state_d = StStart;
            tmr_d   = '0;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge rclk or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            tmr_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign rd_o   = pop;
    assign tx_o   = tx_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed self-checking bench for fifo_uart_tx: one instance at 4 clocks/bit,
// one at 1 clock/bit, both WIDTH=4.
module tb_fifo_uart_tx;

    logic       rclk;
    logic       rst4, rst1;
    logic [3:0] dat4, dat1;
    logic       empty4, empty1;
    logic       rd4, tx4, busy4;
    logic       rd1, tx1, busy1;

    int checks;
    int errors;

    fifo_uart_tx #(.WIDTH(4), .CLKS_PER_BIT(4)) dut4 (
        .rclk   (rclk),
        .rst_i  (rst4),
        .dat_i  (dat4),
        .empty  (empty4),
        .rd_o   (rd4),
        .tx_o   (tx4),
        .busy_o (busy4)
    );

    fifo_uart_tx #(.WIDTH(4), .CLKS_PER_BIT(1)) dut1 (
        .rclk   (rclk),
        .rst_i  (rst1),
        .dat_i  (dat1),
        .empty  (empty1),
        .rd_o   (rd1),
        .tx_o   (tx1),
        .busy_o (busy1)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // Expected line level at cycle j (0..23) of a 4-clocks/bit frame carrying w.
    function automatic logic fbit(input logic [3:0] w, input int j);
        int b;
        b = j / 4;
        if (b == 0) return 1'b0;
        if (b == 5) return 1'b1;
        return w[b-1];
    endfunction

    task automatic test_reset();
        rst4 = 1'b1; rst1 = 1'b1;
        dat4 = 4'h0; dat1 = 4'h0;
        empty4 = 1'b0; empty1 = 1'b0;
        #2;
        checks++; if (tx4 !== 1'b1) begin errors++; $display("FAIL reset_tx4: got %b want 1", tx4); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy4: got %b want 0", busy4); end
        checks++; if (rd4 !== 1'b0) begin errors++; $display("FAIL reset_rd4: got %b want 0", rd4); end
        checks++; if (tx1 !== 1'b1) begin errors++; $display("FAIL reset_tx1: got %b want 1", tx1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1: got %b want 0", busy1); end
        checks++; if (rd1 !== 1'b0) begin errors++; $display("FAIL reset_rd1: got %b want 0", rd1); end
        empty4 = 1'b1; empty1 = 1'b1;
        @(posedge rclk); #1;
        rst4 = 1'b0; rst1 = 1'b0;
        @(posedge rclk); #1;
    endtask

    task automatic test_single_word();
        dat4 = 4'hA; empty4 = 1'b0;
        #1;
        checks++; if (rd4 !== 1'b1) begin errors++; $display("FAIL single_pop: rd got %b want 1", rd4); end
        @(posedge rclk); #1;
        empty4 = 1'b1;
        for (int k = 0; k < 24; k++) begin
            #1;
            checks++;
            if (tx4 !== fbit(4'hA, k) || busy4 !== 1'b1 || rd4 !== 1'b0) begin
                errors++;
                $display("FAIL single_frame k=%0d: tx/busy/rd got %b%b%b want %b10",
                         k, tx4, busy4, rd4, fbit(4'hA, k));
            end
            @(posedge rclk); #1;
        end
        #1;
        checks++;
        if (busy4 !== 1'b0 || tx4 !== 1'b1) begin
            errors++; $display("FAIL single_end: busy/tx got %b%b want 01", busy4, tx4);
        end
    endtask

    task automatic test_back_to_back();
        dat4 = 4'h3; empty4 = 1'b0;
        #1;
        checks++; if (rd4 !== 1'b1) begin errors++; $display("FAIL b2b_pop1: rd got %b want 1", rd4); end
        @(posedge rclk); #1;
        dat4 = 4'hC;
        for (int k = 0; k < 48; k++) begin
            logic [3:0] w;
            empty4 = (k < 24) ? 1'b0 : 1'b1;
            w = (k < 24) ? 4'h3 : 4'hC;
            #1;
            checks++;
            if (tx4 !== fbit(w, k % 24) || busy4 !== 1'b1 || rd4 !== (k == 23)) begin
                errors++;
                $display("FAIL b2b k=%0d: tx/busy/rd got %b%b%b want %b1%b",
                         k, tx4, busy4, rd4, fbit(w, k % 24), (k == 23));
            end
            @(posedge rclk); #1;
        end
        #1;
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL b2b_end: busy got %b want 0", busy4); end
    endtask

    task automatic test_idle();
        empty4 = 1'b1;
        for (int k = 0; k < 100; k++) begin
            #1;
            checks++;
            if (rd4 !== 1'b0 || tx4 !== 1'b1 || busy4 !== 1'b0) begin
                errors++;
                $display("FAIL idle k=%0d: rd/tx/busy got %b%b%b want 010", k, rd4, tx4, busy4);
            end
            @(posedge rclk); #1;
        end
    endtask

    task automatic test_mid_frame_empty();
        dat4 = 4'h9; empty4 = 1'b0;
        #1;
        checks++; if (rd4 !== 1'b1) begin errors++; $display("FAIL mid_pop1: rd got %b want 1", rd4); end
        @(posedge rclk); #1;
        empty4 = 1'b1; dat4 = 4'h6;
        for (int k = 0; k < 48; k++) begin
            logic [3:0] w;
            empty4 = ((k >= 8 && k < 24) || (k >= 30 && k < 34)) ? 1'b0 : 1'b1;
            w = (k < 24) ? 4'h9 : 4'h6;
            #1;
            checks++;
            if (tx4 !== fbit(w, k % 24) || busy4 !== 1'b1 || rd4 !== (k == 23)) begin
                errors++;
                $display("FAIL mid k=%0d: tx/busy/rd got %b%b%b want %b1%b",
                         k, tx4, busy4, rd4, fbit(w, k % 24), (k == 23));
            end
            @(posedge rclk); #1;
        end
        #1;
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL mid_end: busy got %b want 0", busy4); end
    endtask

    task automatic test_reset_mid_frame();
        dat4 = 4'h6; empty4 = 1'b0;
        @(posedge rclk); #1;
        empty4 = 1'b1;
        repeat (5) @(posedge rclk);
        #3;
        checks++; if (tx4 !== 1'b0) begin errors++; $display("FAIL rst_pre: tx got %b want 0", tx4); end
        dat4 = 4'h5; empty4 = 1'b0;
        rst4 = 1'b1;
        #1;
        checks++;
        if (tx4 !== 1'b1 || busy4 !== 1'b0 || rd4 !== 1'b0) begin
            errors++; $display("FAIL rst_async: tx/busy/rd got %b%b%b want 100", tx4, busy4, rd4);
        end
        @(posedge rclk); #3;
        rst4 = 1'b0;
        #1;
        checks++; if (rd4 !== 1'b1) begin errors++; $display("FAIL rst_release_pop: rd got %b want 1", rd4); end
        @(posedge rclk); #1;
        empty4 = 1'b1;
        for (int k = 0; k < 24; k++) begin
            #1;
            checks++;
            if (tx4 !== fbit(4'h5, k) || busy4 !== 1'b1 || rd4 !== 1'b0) begin
                errors++;
                $display("FAIL rst_frame k=%0d: tx/busy/rd got %b%b%b want %b10",
                         k, tx4, busy4, rd4, fbit(4'h5, k));
            end
            @(posedge rclk); #1;
        end
        #1;
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL rst_end: busy got %b want 0", busy4); end
    endtask

    task automatic test_one_clk_per_bit();
        logic exp1 [18];
        exp1 = '{0, 1, 0, 1, 0, 1, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1};
        dat1 = 4'h5; empty1 = 1'b0;
        #1;
        checks++; if (rd1 !== 1'b1) begin errors++; $display("FAIL cpb1_pop1: rd got %b want 1", rd1); end
        @(posedge rclk); #1;
        for (int k = 0; k < 18; k++) begin
            dat1   = (k < 6) ? 4'hF : 4'h0;
            empty1 = (k < 12) ? 1'b0 : 1'b1;
            #1;
            checks++;
            if (tx1 !== exp1[k] || busy1 !== 1'b1 || rd1 !== (k == 5 || k == 11)) begin
                errors++;
                $display("FAIL cpb1 k=%0d: tx/busy/rd got %b%b%b want %b1%b",
                         k, tx1, busy1, rd1, exp1[k], (k == 5 || k == 11));
            end
            @(posedge rclk); #1;
        end
        #1;
        checks++;
        if (busy1 !== 1'b0 || tx1 !== 1'b1) begin
            errors++; $display("FAIL cpb1_end: busy/tx got %b%b want 01", busy1, tx1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_idle();
        test_mid_frame_empty();
        test_reset_mid_frame();
        test_one_clk_per_bit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmitter that drains the read side of the team's FIFO and sends each word on a single line, framed like a UART: one start bit, then WIDTH data bits LSB first, then one stop bit. It runs entirely in the FIFO read clock domain and pops one word per frame. Frames go back-to-back with no idle gap while the FIFO holds data. It is the consumer end of the FIFO's write→read path.

## Interface
- WIDTH, 4: data word width; must match the FIFO WIDTH.
- CLKS_PER_BIT, 16: rclk cycles per serial bit; legal range ≥1.

- rclk  in  1  clock; FIFO read clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- dat_i  in  WIDTH  FIFO read data. Show-ahead: valid whenever empty=0.
- empty  in  1  FIFO empty flag, synchronous to rclk.
- rd_o  out  1  pop strobe. Combinational, high for exactly the one cycle in which the word is taken.
- tx_o  out  1  serial line. Registered; idles at 1.
- busy_o  out  1  registered; 1 while a frame is on the line.

## Operation
- States: IDLE, START, DATA, STOP.
- Registers:
  - bit timer, ceil(log2(CLKS_PER_BIT)) bits, minimum 1 bit; counts 0..CLKS_PER_BIT-1.
  - bit index, ceil(log2(WIDTH)) bits, minimum 1 bit.
  - shift register, WIDTH bits.
- Reset values (async):
  - state=IDLE, tx_o=1, busy_o=0, timer=0, index=0, shift=0.
  - rd_o=0 because state is IDLE; if empty=0 while in reset, rd_o must still be 0 (gate rd_o with !rst_i).
- bit_end = (timer == CLKS_PER_BIT-1). The timer wraps to 0 on bit_end and increments otherwise, in every non-IDLE state.
- rd_o = !empty && (state==IDLE || (state==STOP && bit_end)).
- On a pop edge:
  - shift ← dat_i, state → START, timer ← 0, tx_o ← 0, busy_o ← 1.
- START: on bit_end → DATA, index ← 0, tx_o ← shift[0].
- DATA:
  - On bit_end with index < WIDTH-1: shift ← shift>>1, index++, tx_o ← next LSB.
  - On bit_end with index == WIDTH-1: → STOP, tx_o ← 1.
- STOP: on bit_end:
  - If a pop occurs: behave as the pop edge above. No idle cycle, and busy_o stays 1.
  - Else: → IDLE, busy_o ← 0, tx_o stays 1.
- empty is sampled only at pop opportunities. Changes mid-frame have no effect.
- The FIFO is never popped while empty=1. Underflow is impossible by construction.
- Reset mid-frame: the line returns to 1 immediately. The partially sent word is discarded and is not re-popped.

## Timing
- Pop at edge T (rd_o high in the cycle before T). tx_o falls to 0 in the cycle after T.
- Each bit lasts exactly CLKS_PER_BIT cycles.
- Frame length is exactly (WIDTH+2)*CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle.
- Back-to-back: the next start bit begins the cycle after the last stop-bit cycle. Period = (WIDTH+2)*CLKS_PER_BIT.
- From IDLE: latency from empty falling to rd_o is 0 cycles (combinational). The first tx_o=0 is 1 cycle later.
- busy_o rises with the first start-bit cycle. It falls in the cycle after the final stop bit when no pop occurs.
- CLKS_PER_BIT=1: every cycle is a bit boundary. Frame = WIDTH+2 cycles. Back-to-back streaming has no gaps.

## Test plan
- Single word, WIDTH=4, CLKS_PER_BIT=4. dat_i=4'hA, empty=0 for one pop → tx_o over 24 cycles is 0 (×4), then 0,1,0,1 (×4 each), then 1 (×4). rd_o pulses once; busy_o is high for exactly 24 cycles.
- Back-to-back: words 4'h3 then 4'hC with empty low throughout → second rd_o in the last stop cycle of frame 1. Frame 2's start bit follows immediately. busy_o never drops between frames, and 48 cycles are spent total.
- Idle: empty=1 for 100 cycles → rd_o=0, tx_o=1, busy_o=0 throughout.
- Mid-frame empty toggles: empty falls during DATA of frame 1 → no rd_o until the last STOP cycle, and exactly one pop per frame.
- Reset mid-DATA (assert rst_i asynchronously between edges) → tx_o=1 and busy_o=0 immediately. After release with empty=0, a fresh full frame of the current dat_i is sent.
- CLKS_PER_BIT=1, WIDTH=4: stream 4'h5, 4'hF, 4'h0 → contiguous 18-cycle bit sequence 0,1,0,1,0,1, 0,1,1,1,1,1, 0,0,0,0,0,1 and three rd_o pulses 6 cycles apart.
